obi_mem_adapter: RTL
====================

Name: obi_mem_adapter

Overview:
- Bus adapter between an Ibex OBI-style port (instruction or data) and a single-port synchronous SRAM/ROM macro.
- Generates the grant and response handshakes that the core's memory interface consumes:
  - programmable grant stall;
  - bounded number of outstanding transactions;
  - fixed response latency;
  - range and alignment error checking.
- Instantiated once per core memory port in the top level, replacing ad-hoc gnt registers.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of memory word 0.
- MEM_WORDS, 1024, memory depth in 32-bit words; power of two, at least 2.
- GNT_STALL, 0, idle cycles inserted before each grant (0..15).
- RESP_LAT, 1, cycles from grant to rvalid_o (1..4); must be at least the macro read latency of 1.
- MAX_OUTST, 2, maximum granted-but-unanswered transactions (1..4).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  core request
- gnt_o  out  1  grant; request accepted this cycle
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  read data; 0 on writes and errors
- err_o  out  1  response error, qualified by rvalid_o
- mem_req_o  out  1  macro access strobe
- mem_we_o  out  1  macro write enable
- mem_be_o  out  4  macro byte enables
- mem_addr_o  out  $clog2(MEM_WORDS)  macro word index
- mem_wdata_o  out  32  macro write data
- mem_rdata_i  in  32  macro read data, valid 1 cycle after mem_req_o

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - Reset is synchronous and active-high on rst_i.
  - Under reset, all outputs are 0 and the pipeline, outstanding count and stall counter are cleared.
  - Reset asserted mid-transaction drops in-flight responses: no rvalid_o for them after reset.
- Grant FSM, states IDLE / STALL / GRANT:
  - IDLE: when req_i=1 and GNT_STALL=0 and outst<MAX_OUTST, go to GRANT (combinational gnt this cycle). When req_i=1 and GNT_STALL>0, load the counter and go to STALL.
  - STALL: count down. At 0 with req_i still high and capacity available, assert gnt_o; otherwise return to IDLE.
  - When outst==MAX_OUTST, gnt_o stays 0 even if the stall has expired.
  - req_i dropping before grant aborts the transaction silently.
- Core request signals are sampled only in a cycle where req_i&gnt_o.
- Error checks:
  - Error if addr_i[1:0]!=0.
  - Error if addr_i-ADDR_BASE >= MEM_WORDS*4. This is an unsigned subtract, so addresses below ADDR_BASE wrap and are flagged.
  - An errored access does not assert mem_req_o.
- Macro access:
  - A granted non-error access drives mem_req_o=1 in the grant cycle, combinationally from the core signals.
  - mem_addr_o = (addr_i-ADDR_BASE)[2 +: log2(MEM_WORDS)].
- Response pipeline:
  - Shift register of depth RESP_LAT carrying {valid, err, we}.
  - Stage RESP_LAT-1 drives rvalid_o and err_o.
  - rdata_o = mem_rdata_i, captured one cycle after grant and held in a register when RESP_LAT>1. It is forced to 0 if we or err.
  - Responses emerge in grant order, exactly RESP_LAT cycles after their grant. Back-to-back grants give back-to-back rvalid_o.
- Outstanding count:
  - outst increments on grant and decrements on rvalid_o.
  - A simultaneous grant and rvalid_o leaves it unchanged.
  - It never exceeds MAX_OUTST (assert).

Decomposition:
- Package obi_mem_pkg holds:
  - the resp_stage_t struct {valid, err, we};
  - the grant FSM state enum;
  - the range and limit constants for the parameters.
- One sub-module, obi_resp_pipe, implements the RESP_LAT-deep response shift register with data capture.

Test Plan:
- Single read: GNT_STALL=0, RESP_LAT=1, word 5 = 32'hDEADBEEF, read addr 0x14.
  - Expect gnt_o in the same cycle.
  - Expect rvalid_o next cycle with rdata_o=DEADBEEF, err_o=0.
- Streamed reads: req_i held high for 4 consecutive reads, MAX_OUTST=2, RESP_LAT=2.
  - Expect gnt_o pattern 1,1,0,1,1 (third grant waits for the first response).
  - Expect responses in order.
- Write then read: write be=4'b0011 data 0x12345678 to addr 0x8 (word 2, initially 0), then read addr 0x8.
  - Expect the write response with rdata_o=0.
  - Expect the read to return 0x00005678.
- Errors: read addr 0x2, then addr MEM_WORDS*4.
  - Expect both granted, mem_req_o=0, rvalid_o with err_o=1 and rdata_o=0.
- Grant stall: GNT_STALL=3, request held high.
  - Expect gnt_o on the 4th cycle of req_i.
  - Drop req_i during the stall: expect no gnt_o and no rvalid_o.
- Reset mid-flight: assert rst_i one cycle after a grant with RESP_LAT=3.
  - Expect no rvalid_o afterwards, outst=0, and the next request granted normally.

Source files
------------

// File: rtl/obi_mem_pkg.sv
// obi_mem_pkg: shared types and parameter limits for the OBI memory adapter
// Contents: resp_stage_t response pipeline entry, gnt_state_t grant FSM
// states, legal parameter ranges and the counter widths derived from them.
package obi_mem_pkg;

    localparam int unsigned GNT_STALL_MAX = 15;
    localparam int unsigned RESP_LAT_MIN  = 1;
    localparam int unsigned RESP_LAT_MAX  = 4;
    localparam int unsigned MAX_OUTST_MAX = 4;
    localparam int unsigned STALL_W       = $clog2(GNT_STALL_MAX + 1);
    localparam int unsigned OUTST_W       = $clog2(MAX_OUTST_MAX + 1);

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } resp_stage_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_GRANT
    } gnt_state_t;

endpackage

// File: rtl/obi_resp_pipe.sv
// obi_resp_pipe: fixed-latency response shift register with read data capture
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   push, push_err, push_we transaction granted this cycle and its attributes
//   mem_rdata              macro read data, valid one cycle after the push
//   rvalid, err, rdata     response, DEPTH cycles after the push
module obi_resp_pipe
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  logic        push_err,
    input  logic        push_we,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);

    resp_stage_t stage_q [DEPTH];
    resp_stage_t tail;
    logic [31:0] data;

    always_ff @(posedge clk_i) begin
        stage_q[0] <= rst_i ? '0 : resp_stage_t'{valid: push, err: push_err, we: push_we};
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= rst_i ? '0 : stage_q[i-1];
    end

    // Macro data lands alongside stage 0; deeper pipes carry it next to the
    // matching stage so several outstanding reads keep their own words.
    if (DEPTH == 1) begin : g_direct
        assign data = mem_rdata;
    end else begin : g_hold
        logic [31:0] data_q [DEPTH-1:1];
        always_ff @(posedge clk_i) begin
            data_q[1] <= mem_rdata;
            for (int i = 2; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        end
        assign data = data_q[DEPTH-1];
    end

    assign tail   = stage_q[DEPTH-1];
    assign rvalid = tail.valid && !rst_i;
    assign err    = rvalid && tail.err;
    assign rdata  = (rvalid && !tail.err && !tail.we) ? data : 32'b0;

endmodule

// File: rtl/obi_mem_adapter.sv
// obi_mem_adapter: OBI grant/response handshake in front of a single-port SRAM/ROM macro
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   req_i, gnt_o                       core request / grant
//   addr_i, we_i, be_i, wdata_i        core request attributes, sampled on req_i & gnt_o
//   rvalid_o, rdata_o, err_o           core response
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o            macro access, driven in the grant cycle
//   mem_rdata_i                        macro read data, one cycle after mem_req_o
module obi_mem_adapter
    import obi_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned GNT_STALL = 0,
    parameter int unsigned RESP_LAT  = 1,
    parameter int unsigned MAX_OUTST = 2,
    localparam int unsigned AW = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic [31:0]   addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    gnt_state_t         state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic [OUTST_W-1:0] outst_q;
    logic [31:0]        off;
    logic               room, gnt, addr_err;

    // Unsigned offset: addresses below ADDR_BASE wrap high and fail the range test.
    assign off      = addr_i - ADDR_BASE;
    assign addr_err = (addr_i[1:0] != 2'b00) || ((off >> (AW + 2)) != 32'd0);
    assign room     = outst_q < OUTST_W'(MAX_OUTST);

    // GRANT behaves like IDLE so a held request can be granted back to back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            ST_STALL: begin
                if (!req_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - STALL_W'(1);
                end else begin
                    gnt     = room;
                    state_d = room ? ST_GRANT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (req_i && GNT_STALL == 0) begin
                    gnt     = room;
                    state_d = room ? ST_GRANT : ST_IDLE;
                end else if (req_i) begin
                    cnt_d   = STALL_W'(GNT_STALL - 1);
                    state_d = ST_STALL;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        state_q <= rst_i ? ST_IDLE : state_d;
        cnt_q   <= rst_i ? '0 : cnt_d;
        outst_q <= rst_i ? '0 : outst_q + OUTST_W'(gnt_o) - OUTST_W'(rvalid_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (outst_q <= OUTST_W'(MAX_OUTST));
            assert (GNT_STALL <= GNT_STALL_MAX && RESP_LAT >= RESP_LAT_MIN &&
                    RESP_LAT <= RESP_LAT_MAX && MAX_OUTST >= 1 &&
                    MAX_OUTST <= MAX_OUTST_MAX && MEM_WORDS >= 2);
        end
    end

    assign gnt_o       = gnt && !rst_i;
    assign mem_req_o   = gnt_o && !addr_err;
    assign mem_we_o    = mem_req_o && we_i;
    assign mem_be_o    = mem_req_o ? be_i : 4'b0;
    assign mem_addr_o  = mem_req_o ? off[2 +: AW] : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i : 32'b0;

    obi_resp_pipe #(
        .DEPTH(RESP_LAT)
    ) u_resp (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (gnt_o),
        .push_err (addr_err),
        .push_we  (we_i),
        .mem_rdata(mem_rdata_i),
        .rvalid   (rvalid_o),
        .err      (err_o),
        .rdata    (rdata_o)
    );

endmodule
